// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: glyph table, blank level and segment bit positions.
// Segment order within a glyph is {g, f, e, d, c, b, a}.
package seg7_pkg;

   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry n is the hex glyph for code n: 0-9, then A, b, C, d, E, F.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder; BCD mode blanks codes 10-15.
module seg7_glyph (
   input  logic [3:0] nibble_i,
   input  logic       hex_mode_i,
   output logic [6:0] glyph_o
);
   import seg7_pkg::*;

   always_comb begin
      glyph_o = GLYPH_TABLE[nibble_i];
      if (!hex_mode_i && (nibble_i > 4'd9)) begin
         glyph_o = SEG_OFF;
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits over a shared segment bus and
// swaps in newly loaded values only at a frame boundary so the display never tears.
module seg7_scan_decoder #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 1024,
   parameter int unsigned HEX_MODE   = 0,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_valid_i,
   output logic                    load_ready_o,
   input  logic [4*NUM_DIGITS-1:0] load_data_i,
   input  logic                    blank_lz_i,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   digit_en_o,
   output logic                    err_o
);
   import seg7_pkg::*;

   localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DivW  = $clog2(SCAN_DIV);
   localparam int unsigned DataW = 4 * NUM_DIGITS;

   localparam logic [DivW-1:0]       DivMax = DivW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0]       IdxMax = IdxW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SegPol = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DigPol = {NUM_DIGITS{ACTIVE_LOW != 0}};

   logic [DivW-1:0]       div_q, div_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [DataW-1:0]      active_q, active_d;
   logic [DataW-1:0]      pending_q, pending_d;
   logic                  pend_q, pend_d;
   logic                  err_q, err_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

   logic                  accept;
   logic                  div_wrap;
   logic                  frame_end;
   logic                  bcd_bad;
   logic [3:0]            cur_nib;
   logic                  cur_lz;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] lead_zero;
   logic [6:0]            glyph;

   seg7_glyph u_glyph (
      .nibble_i   (cur_nib),
      .hex_mode_i (HEX_MODE != 0),
      .glyph_o    (glyph)
   );

   assign load_ready_o = !pend_q;
   assign accept       = load_valid_i && !pend_q;
   assign div_wrap     = (div_q == DivMax);
   assign frame_end    = div_wrap && (idx_q == IdxMax);

   always_comb begin
      bcd_bad = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (load_data_i[4*k +: 4] > 4'd9) begin
            bcd_bad = 1'b1;
         end
      end
   end

   // lead_zero[k]: digit k and every more-significant digit are zero.
   always_comb begin
      zero_run  = 1'b1;
      lead_zero = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run && (active_q[4*k +: 4] == 4'd0);
         lead_zero[k] = zero_run;
      end
   end

   always_comb begin
      cur_nib = 4'd0;
      cur_lz  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IdxW'(k)) begin
            cur_nib = active_q[4*k +: 4];
            cur_lz  = lead_zero[k];
         end
      end
   end

   always_comb begin
      div_d     = div_wrap ? '0 : div_q + 1'b1;
      idx_d     = idx_q;
      active_d  = active_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      err_d     = err_q;

      if (div_wrap) begin
         idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      end

      // Ready is low whenever a transfer is due, so these branches never overlap.
      if (accept) begin
         pending_d = load_data_i;
         pend_d    = 1'b1;
         if ((HEX_MODE == 0) && bcd_bad) begin
            err_d = 1'b1;
         end
      end else if (frame_end && pend_q) begin
         active_d = pending_q;
         pend_d   = 1'b0;
      end

      if (blank_lz_i && (idx_q != '0) && cur_lz) begin
         seg_d = SEG_OFF ^ SegPol;
      end else begin
         seg_d = glyph ^ SegPol;
      end

      digit_en_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit_en_d[k] = (idx_q == IdxW'(k));
      end
      digit_en_d = digit_en_d ^ DigPol;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q      <= '0;
         idx_q      <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         pend_q     <= 1'b0;
         err_q      <= 1'b0;
         seg_q      <= SEG_OFF ^ SegPol;
         digit_en_q <= DigPol;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         pend_q     <= pend_d;
         err_q      <= err_d;
         seg_q      <= seg_d;
         digit_en_q <= digit_en_d;
      end
   end

   assign seg_o      = seg_q;
   assign digit_en_o = digit_en_q;
   assign err_o      = err_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Parametrised, clocked successor to the single-segment BCD decoders in the seven-segment benchmark set. It decodes all seven segments from one 4-bit code, either BCD or full hex. It time-multiplexes NUM_DIGITS digits onto one shared segment bus with a one-hot digit strobe. New values are accepted through a valid/ready handshake and become visible only at a frame boundary, so the display never tears.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, ≥1.
- SCAN_DIV, 1024: clock cycles each digit is driven, ≥2.
- HEX_MODE, 0: 0 = BCD, codes 10–15 are blanked and flagged; 1 = hex glyphs A,b,C,d,E,F.
- ACTIVE_LOW, 0: 1 inverts seg and digit_en, including their reset and off levels.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a load.
- load_data  in  4*NUM_DIGITS  nibble k drives digit k; digit 0 is the least significant, at [3:0].
- blank_lz  in  1  enables leading-zero blanking; level-sensitive, evaluated every cycle.
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- digit_en  out  NUM_DIGITS  one-hot digit strobe.
- err  out  1  sticky flag: a BCD-mode load contained a nibble greater than 9.

## Operation
- Registers:
  - div counter, 0..SCAN_DIV-1
  - digit index idx, 0..NUM_DIGITS-1
  - active value register
  - pending value register, plus a pending flag
- Handshake:
  - load_ready = !pending.
  - A load is accepted when load_valid && load_ready: load_data goes into pending and the pending flag is set.
  - load_data is ignored when ready is low; the source must hold it.
- Frame boundary: the cycle in which div == SCAN_DIV-1 and idx == NUM_DIGITS-1.
  - If pending is set: active ← pending and the pending flag clears.
  - Accept and transfer can never coincide, because ready is low whenever a transfer is possible.
- Scan:
  - When div reaches SCAN_DIV-1, div wraps to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
- Glyphs (a..g, hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - In BCD mode, codes 10–15 produce 00 (blank).
- Leading-zero blanking:
  - With blank_lz=1, digit k>0 is blanked (seg off) when digit k and all more-significant digits are 0.
  - Digit 0 is never blanked.
  - digit_en still strobes blanked digits.
- err:
  - Set on an accepted load when HEX_MODE=0 and any nibble >9.
  - Cleared only by rst.
  - Never set when HEX_MODE=1.
- Polarity: the ACTIVE_LOW inversion is applied at the output registers only.

## Timing
- Reset (rst high at a clock edge):
  - div=0, idx=0, active=0, pending cleared, err=0, load_ready=1.
  - seg = off (7'h00, or 7'h7F if ACTIVE_LOW).
  - digit_en = all off (0, or all-ones if ACTIVE_LOW).
- First edge after rst falls: digit_en = one-hot digit 0, seg = glyph of active digit 0.
- Output latency: seg and digit_en are registered, one cycle behind idx/active. A new idx or active value appears on the outputs on the following edge.
- load_ready falls in the cycle after acceptance. It rises in the cycle after the frame-boundary transfer.
- Worst-case load-to-display: NUM_DIGITS*SCAN_DIV + 1 cycles.
- Reset mid-operation: pending data is discarded, the display returns to zeros, and scanning restarts at digit 0.

## Structure
- seg7_pkg holds:
  - the 16-entry glyph constant table
  - SEG_OFF = 7'h00
  - the segment index constants SEG_A..SEG_G
- One sub-module, seg7_glyph: combinational nibble + hex_mode → 7-bit glyph, reused by the single-segment benchmarks.
- The top level holds the counters, handshake, blanking logic and output registers.

## Test plan
- Reset and defaults (NUM_DIGITS=4, SCAN_DIV=4):
  - rst high for 3 cycles → seg=00, digit_en=0000, load_ready=1, err=0.
  - First cycle after release → digit_en=0001, seg=3F.
- Deferred load:
  - Accept 16'h1234 while idx=1 → load_ready=0.
  - Digits 1–3 still show 3F.
  - After the boundary: digit0 shows 66, digit3 shows 06, load_ready=1.
- Leading-zero blanking: load 16'h0050 with blank_lz=1 → digit3=00, digit2=00, digit1=6D, digit0=3F.
  - Toggling blank_lz to 0 → digit3 and digit2 show 3F.
- BCD error:
  - HEX_MODE=0, load 16'h00A3 → err=1 (sticky across a subsequent load of 16'h0000), digit1=00.
  - HEX_MODE=1, same load → digit1=77, err=0.
- Active-low:
  - ACTIVE_LOW=1 reset → seg=7F, digit_en=1111.
  - Digit 8 → seg=00, strobe of the active digit=0.
- Reset with pending load: accept 16'h9999, then assert rst before the boundary → load_ready=1, all digits show 3F, 9 never appears.
